// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory-system bus shared by the fetch port, the data port and
// the memory system around mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ack;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  mem_re;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_stall;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  owner_dm;
  logic                  timeout_err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_stall, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_re, mem_we, mem_addr, mem_wdata,
    output busy, owner_dm, timeout_err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_stall, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_re, mem_we, mem_addr, mem_wdata,
    input  busy, owner_dm, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port stalling memory system.
// Define ARB_DATA_PRIORITY_EN to give the data port fixed priority instead of round-robin.
module mem_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int STALL_TIMEOUT = 64
) (
    input logic             clk,
    input logic             reset_n,
    mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]            state_r;
  logic                  req_any_s;
  logic                  grant_dm_s;
  logic                  owner_dm_r;
  logic                  busy_r;
  logic                  timeout_err_r;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic                  if_ack_r;
  logic                  dm_ack_r;
  logic [DATA_WIDTH-1:0] if_rdata_r;
  logic [DATA_WIDTH-1:0] dm_rdata_r;
  logic                  mem_re_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
`ifdef ARB_DATA_PRIORITY_EN
`else
  logic                  last_dm_r;
`endif

  // Winner selection for a grant issued from IDLE
  always_comb begin
    req_any_s  = bus.if_req | bus.dm_req;
    grant_dm_s = 1'b0;
`ifdef ARB_DATA_PRIORITY_EN
    grant_dm_s = bus.dm_req;
`else
    if (bus.if_req && bus.dm_req) begin
      grant_dm_s = ~last_dm_r;
    end else begin
      grant_dm_s = bus.dm_req;
    end
`endif
  end

  // Transaction FSM; the mem_* registers double as the latched request copy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      owner_dm_r    <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      stall_cnt_r   <= {CNT_W{1'b0}};
      if_ack_r      <= 1'b0;
      dm_ack_r      <= 1'b0;
      if_rdata_r    <= {DATA_WIDTH{1'b0}};
      dm_rdata_r    <= {DATA_WIDTH{1'b0}};
      mem_re_r      <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r   <= {DATA_WIDTH{1'b0}};
`ifdef ARB_DATA_PRIORITY_EN
`else
      last_dm_r     <= 1'b1;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_any_s) begin
            state_r     <= S_ISSUE;
            busy_r      <= 1'b1;
            owner_dm_r  <= grant_dm_s;
            stall_cnt_r <= {CNT_W{1'b0}};
            mem_re_r    <= ~(grant_dm_s & bus.dm_we);
            mem_we_r    <= grant_dm_s & bus.dm_we;
            mem_addr_r  <= grant_dm_s ? bus.dm_addr : bus.if_addr;
            mem_wdata_r <= grant_dm_s ? bus.dm_wdata : {DATA_WIDTH{1'b0}};
`ifdef ARB_DATA_PRIORITY_EN
`else
            last_dm_r   <= grant_dm_s;
`endif
          end
        end
        S_ISSUE: begin
          if (bus.mem_stall) begin
            if (stall_cnt_r != CNT_W'(STALL_TIMEOUT)) begin
              stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (stall_cnt_r == CNT_W'(STALL_TIMEOUT - 1)) begin
              timeout_err_r <= 1'b1;
            end
          end else begin
            state_r     <= S_RESP;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            if (owner_dm_r) begin
              dm_ack_r <= 1'b1;
              // Writes leave the data port's last read result untouched
              if (!mem_we_r) begin
                dm_rdata_r <= bus.mem_rdata;
              end
            end else begin
              if_ack_r   <= 1'b1;
              if_rdata_r <= bus.mem_rdata;
            end
          end
        end
        S_RESP: begin
          state_r  <= S_IDLE;
          busy_r   <= 1'b0;
          if_ack_r <= 1'b0;
          dm_ack_r <= 1'b0;
        end
        default: begin
          state_r  <= S_IDLE;
          busy_r   <= 1'b0;
          if_ack_r <= 1'b0;
          dm_ack_r <= 1'b0;
          mem_re_r <= 1'b0;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_ack      = if_ack_r;
  assign bus.if_rdata    = if_rdata_r;
  assign bus.dm_ack      = dm_ack_r;
  assign bus.dm_rdata    = dm_rdata_r;
  assign bus.mem_re      = mem_re_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wdata   = mem_wdata_r;
  assign bus.busy        = busy_r;
  assign bus.owner_dm    = owner_dm_r;
  assign bus.timeout_err = timeout_err_r;
endmodule
